testio_host_wb: RTL and testbench
=================================

// Module: testio_host_wb
// PURPOSE
//  Wishbone slave that initiates TestIO serial transactions: each WB access is serialised
//  onto test_dout as a request frame, and the response frame on test_din is deserialised
//  into ack/err/rdata. Host-side counterpart of the on-chip TestIO WB master; used in
//  perips as a bench/bring-up driver and for chip-to-chip TestIO links.
// PARAMETERS
//  AW       32    WB address width; must be 32 (frame carries 32 address bits)
//  DW       32    WB data width; must be 32
//  CLK_DIV  4     clk cycles per serial bit; even, >=2
//  TIMEOUT  1024  clk cycles in WAIT_RSP before the access is failed with err
// PORTS
//  clk            in   1       single clock
//  rst            in   1       asynchronous, active-high reset
//  wbs_cyc_i      in   1       WB cycle
//  wbs_stb_i      in   1       WB strobe
//  wbs_we_i       in   1       1=write
//  wbs_addr_i     in   AW      byte address
//  wbs_wdata_i    in   DW      write data
//  wbs_sel_i      in   DW/8    byte selects
//  wbs_rdata_o    out  DW      read data, valid with ack
//  wbs_ack_o      out  1       one-cycle completion pulse
//  wbs_err_o      out  1       one-cycle error pulse (remote error or timeout)
//  test_dout      out  1       serial request line, idle 1
//  test_doen      out  1       active-high output enable for test_dout
//  test_din       in   1       serial response line, idle 1
//  busy_o         out  1       1 from acceptance until ack/err
// BEHAVIOUR
//  Reset: test_dout=1, test_doen=0, ack=0, err=0, rdata=0, busy_o=0, FSM=IDLE; asserting
//   rst mid-frame aborts immediately, no ack/err, line returns to idle.
//  test_din passes through a 2-flop synchroniser before use.
//  Accept: in IDLE, cyc&stb high -> latch we/addr/wdata/sel, busy_o=1, go SEND next cycle.
//  Request frame (MSB first, each bit held CLK_DIV cycles, test_doen=1):
//   start 0, cmd (1=wr), addr[31:0]; write adds sel[3:0], wdata[31:0].
//   Read = 34 bits, write = 70 bits.
//  TURN: drive 1 for one bit period, then test_doen=0 -> WAIT_RSP.
//  WAIT_RSP: timeout counter counts clk; synced din==0 -> RECV; counter reaching TIMEOUT
//   -> DONE with err, rdata unchanged.
//  RECV: re-check din at CLK_DIV/2 (still 0 = valid start, else back to WAIT_RSP,
//   counter not reset); then sample every CLK_DIV: status bit (0=ok, 1=err), read adds
//   data[31:0] MSB first shifted into rx register.
//  DONE: one cycle; ack=1 if status ok else err=1 (never both); rdata updated only on
//   read with ok status; busy_o=0 same cycle; back to IDLE next cycle.
//  WB abort: cyc dropping during access does not stop the frame; completion pulse
//   suppressed (frame must finish to keep remote in sync). New request accepted only in IDLE.
//  stb held through DONE is not re-accepted that cycle; accepted next IDLE cycle only if
//   still asserted (WB master must drop stb on ack).
//  Counters: bit counter 7 bits, divider log2(CLK_DIV) bits, timeout ceil(log2(TIMEOUT+1)).
// TESTING
//  Read 0x1000_0004, CLK_DIV=4: 34-bit frame 0,0,addr MSB first, 136 cycles; model returns
//   0,0,0xDEADBEEF -> single ack, rdata=0xDEADBEEF, err=0.
//  Write 0x2000_0000 data 0x1234_5678 sel 0xF -> 70-bit frame ends ...1111,0x12345678;
//   model returns 0,0 -> ack, rdata unchanged.
//  Remote status 1 on read -> err pulse, no ack, rdata retains previous value.
//  No response, TIMEOUT=1024 -> err exactly 1024 cycles after doen falls; FSM IDLE.
//  Glitch: din low 1 cycle in WAIT_RSP -> ignored; real response later -> normal ack.
//  rst asserted at bit 20 of write -> outputs at reset values same edge; next read works.

Source files
------------

// File: rtl/testio_host_wb.sv
// Wishbone slave that runs each access as a TestIO request frame and waits for the response frame.
// Latency: whole serial round trip; one access at a time (busy_o), strobes are taken only in IDLE.
module testio_host_wb #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int CLK_DIV = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wbs_cyc_i,
   input  logic            wbs_stb_i,
   input  logic            wbs_we_i,
   input  logic [AW-1:0]   wbs_addr_i,
   input  logic [DW-1:0]   wbs_wdata_i,
   input  logic [DW/8-1:0] wbs_sel_i,
   output logic [DW-1:0]   wbs_rdata_o,
   output logic            wbs_ack_o,
   output logic            wbs_err_o,
   output logic            test_dout,
   output logic            test_doen,
   input  logic            test_din,
   output logic            busy_o
);

   localparam int FRAME_W = 2 + AW + DW/8 + DW;
   localparam int DIV_W   = $clog2(CLK_DIV);
   localparam int TMO_W   = $clog2(TIMEOUT + 1);

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV/2 - 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
   localparam logic [6:0]       WR_LAST   = 7'(FRAME_W - 1);
   localparam logic [6:0]       RD_LAST   = 7'(2 + AW - 1);
   localparam logic [6:0]       RX_RD_LAST = 7'(DW);

   typedef enum logic [2:0] {
      S_IDLE, S_SEND, S_TURN, S_WAIT, S_RECV, S_DONE
   } state_t;

   state_t               state;
   logic [FRAME_W-1:0]   tx_sr;
   logic [6:0]           bit_cnt;
   logic [DIV_W-1:0]     div_cnt;
   logic [TMO_W-1:0]     tmo_cnt;
   logic [DW-2:0]        rx_sr;
   logic                 rx_hunt;
   logic                 status_q;
   logic                 we_q;
   logic                 aborted;
   logic                 din_meta;
   logic                 din_sync;

   logic                 fin_vld;
   logic                 fin_err;
   logic                 fin_rd_ok;
   logic                 report;
   logic [6:0]           tx_last;
   logic [6:0]           rx_last;

   assign tx_last = we_q ? WR_LAST : RD_LAST;
   assign rx_last = we_q ? 7'd0 : RX_RD_LAST;
   // A master that dropped cyc mid-access still lets the frame finish, but gets no pulse.
   assign report  = wbs_cyc_i && !aborted;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         din_meta <= 1'b1;
         din_sync <= 1'b1;
      end else begin
         din_meta <= test_din;
         din_sync <= din_meta;
      end
   end

   always_comb begin
      fin_vld   = 1'b0;
      fin_err   = 1'b0;
      fin_rd_ok = 1'b0;
      case (state)
         S_WAIT: begin
            if (din_sync && tmo_cnt == TMO_LAST) begin
               fin_vld = 1'b1;
               fin_err = 1'b1;
            end
         end
         S_RECV: begin
            if (!rx_hunt && div_cnt == DIV_LAST && bit_cnt == rx_last) begin
               fin_vld   = 1'b1;
               fin_err   = (bit_cnt == 7'd0) ? din_sync : status_q;
               fin_rd_ok = !we_q && !fin_err;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         tx_sr       <= '0;
         bit_cnt     <= '0;
         div_cnt     <= '0;
         tmo_cnt     <= '0;
         rx_sr       <= '0;
         rx_hunt     <= 1'b0;
         status_q    <= 1'b0;
         we_q        <= 1'b0;
         aborted     <= 1'b0;
         test_dout   <= 1'b1;
         test_doen   <= 1'b0;
         wbs_ack_o   <= 1'b0;
         wbs_err_o   <= 1'b0;
         wbs_rdata_o <= '0;
         busy_o      <= 1'b0;
      end else begin
         wbs_ack_o <= 1'b0;
         wbs_err_o <= 1'b0;
         if (state != S_IDLE && !wbs_cyc_i) aborted <= 1'b1;

         case (state)
            S_IDLE: begin
               if (wbs_cyc_i && wbs_stb_i) begin
                  we_q      <= wbs_we_i;
                  tx_sr     <= {1'b0, wbs_we_i, wbs_addr_i, wbs_sel_i, wbs_wdata_i};
                  test_doen <= 1'b1;
                  test_dout <= 1'b0;
                  busy_o    <= 1'b1;
                  div_cnt   <= '0;
                  bit_cnt   <= '0;
                  aborted   <= 1'b0;
                  state     <= S_SEND;
               end
            end
            S_SEND: begin
               div_cnt <= div_cnt + DIV_W'(1);
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (bit_cnt == tx_last) begin
                     test_dout <= 1'b1;
                     state     <= S_TURN;
                  end else begin
                     test_dout <= tx_sr[FRAME_W-2];
                     tx_sr     <= tx_sr << 1;
                     bit_cnt   <= bit_cnt + 7'd1;
                  end
               end
            end
            S_TURN: begin
               div_cnt <= div_cnt + DIV_W'(1);
               if (div_cnt == DIV_LAST) begin
                  div_cnt   <= '0;
                  test_doen <= 1'b0;
                  tmo_cnt   <= '0;
                  state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (!din_sync) begin
                  div_cnt <= '0;
                  rx_hunt <= 1'b1;
                  state   <= S_RECV;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            S_RECV: begin
               div_cnt <= div_cnt + DIV_W'(1);
               if (rx_hunt) begin
                  // Mid-start re-check rejects single-cycle glitches; the timeout keeps running.
                  if (div_cnt == HALF_LAST) begin
                     if (din_sync) begin
                        state <= S_WAIT;
                     end else begin
                        rx_hunt <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                     end
                  end
               end else if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  bit_cnt <= bit_cnt + 7'd1;
                  if (bit_cnt == 7'd0) status_q <= din_sync;
                  else                 rx_sr    <= {rx_sr[DW-3:0], din_sync};
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         if (fin_vld) begin
            state     <= S_DONE;
            busy_o    <= 1'b0;
            wbs_ack_o <= !fin_err && report;
            wbs_err_o <= fin_err && report;
            if (fin_rd_ok) wbs_rdata_o <= {rx_sr, din_sync};
         end
      end
   end

endmodule

// File: tb/tb_testio_host_wb.sv
// Scoreboard bench for testio_host_wb: a behavioural TestIO remote decodes request frames and
// answers them, while a monitor checks every ack/err against expectations queued at issue time.
module tb_testio_host_wb;
   localparam int CLK_DIV = 4;
   localparam int TIMEOUT = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
   logic [31:0] wbs_addr_i = '0, wbs_wdata_i = '0;
   logic [3:0]  wbs_sel_i = '0;
   logic [31:0] wbs_rdata_o;
   logic        wbs_ack_o, wbs_err_o, test_dout, test_doen, busy_o;
   logic        test_din = 1'b1;

   testio_host_wb #(.AW(32), .DW(32), .CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
      .wbs_addr_i(wbs_addr_i), .wbs_wdata_i(wbs_wdata_i), .wbs_sel_i(wbs_sel_i),
      .wbs_rdata_o(wbs_rdata_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
      .test_dout(test_dout), .test_doen(test_doen), .test_din(test_din), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct { bit is_err; logic [31:0] rdata; } exp_t;
   typedef struct { logic [71:0] bits; int nbits; } frame_t;
   typedef struct { bit silent; bit status; bit glitch; bit is_read; logic [31:0] data; int delay; } rsp_t;

   exp_t   exp_q[$];
   frame_t frame_q[$];
   rsp_t   rsp_q[$];

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] model_rdata = '0;
   int unsigned fall_cyc = 0;
   bit          rst_abort = 1'b0;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic rsp_t mk_rsp(input bit silent, input bit status, input bit glitch,
                                   input logic [31:0] data, input int delay);
      rsp_t r;
      r.silent = silent; r.status = status; r.glitch = glitch;
      r.is_read = 1'b0; r.data = data; r.delay = delay;
      return r;
   endfunction

   task automatic drive_bit(input logic b);
      test_din = b;
      repeat (CLK_DIV) @(negedge clk);
   endtask

   // Completion monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && (wbs_ack_o || wbs_err_o)) begin
            check("ack_err_exclusive", {71'd0, wbs_ack_o & wbs_err_o}, 72'd0);
            check("busy_at_done", {71'd0, busy_o}, 72'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_completion", 72'd1, 72'd0);
            end else begin
               e = exp_q.pop_front();
               check("completion_kind_err", {71'd0, wbs_err_o}, {71'd0, e.is_err});
               check("rdata", {40'd0, wbs_rdata_o}, {40'd0, e.rdata});
            end
         end
      end
   end

   // Behavioural remote: samples mid-bit, then answers start/status/data after a delay.
   initial begin
      logic [71:0] rx;
      int          cnt;
      bit          aborted;
      frame_t      f;
      rsp_t        r;
      forever begin
         @(negedge clk);
         if (test_doen === 1'b1) begin
            rx = '0;
            cnt = 0;
            while (test_doen === 1'b1) begin
               if (cnt % CLK_DIV == CLK_DIV/2 && cnt / CLK_DIV < 72) rx = {rx[70:0], test_dout};
               cnt++;
               @(negedge clk);
            end
            fall_cyc = cyc;
            aborted = rst_abort;
            if (frame_q.size() == 0) begin
               check("unexpected_frame", 72'd1, 72'd0);
            end else begin
               f = frame_q.pop_front();
               if (!aborted) begin
                  check("frame_bits", rx, f.bits);
                  check("frame_cycles", 72'(cnt), 72'((f.nbits + 1) * CLK_DIV));
                  if (rsp_q.size() > 0) begin
                     r = rsp_q.pop_front();
                     if (!r.silent) begin
                        repeat (r.delay) @(negedge clk);
                        if (r.glitch) begin
                           test_din = 1'b0;
                           @(negedge clk);
                           test_din = 1'b1;
                           repeat (8) @(negedge clk);
                        end
                        drive_bit(1'b0);
                        drive_bit(r.status);
                        if (r.is_read)
                           for (int i = 31; i >= 0; i--) drive_bit(r.data[i]);
                        test_din = 1'b1;
                     end
                  end
               end
            end
         end
      end
   end

   task automatic queue_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] sel, input rsp_t r, input bit expect_done);
      frame_t f;
      exp_t   e;
      rsp_t   rr;
      f.nbits = we ? 70 : 34;
      f.bits  = we ? {1'b0, 1'b0, 1'b1, addr, sel, wdata, 1'b1}
                   : {37'd0, 1'b0, 1'b0, addr, 1'b1};
      frame_q.push_back(f);
      rr = r;
      rr.is_read = !we;
      rsp_q.push_back(rr);
      if (expect_done) begin
         e.is_err = r.silent || r.status;
         e.rdata  = (!we && !e.is_err) ? r.data : model_rdata;
         model_rdata = e.rdata;
         exp_q.push_back(e);
      end
   endtask

   task automatic wb_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] sel, input rsp_t r, input bit hold_stb,
                            output int unsigned done_cyc);
      int t;
      queue_access(we, addr, wdata, sel, r, 1'b1);
      @(negedge clk);
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
      wbs_addr_i = addr; wbs_wdata_i = wdata; wbs_sel_i = sel;
      t = 0;
      do begin
         @(negedge clk);
         t++;
         if (t == 1) check("busy_after_accept", {71'd0, busy_o}, 72'd1);
      end while (!(wbs_ack_o || wbs_err_o) && t < 4000);
      if (t >= 4000) check("completion_timeout", 72'd1, 72'd0);
      done_cyc = cyc;
      if (hold_stb) begin
         @(negedge clk);
         check("stb_through_done_busy", {71'd0, busy_o}, 72'd0);
      end
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      @(negedge clk);
      check("pulse_one_cycle", {70'd0, wbs_ack_o, wbs_err_o}, 72'd0);
      check("idle_after_done", {70'd0, busy_o, test_doen}, 72'd0);
      repeat (6) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_dout"},  {71'd0, test_dout}, 72'd1);
      check({tag, "_doen"},  {71'd0, test_doen}, 72'd0);
      check({tag, "_busy"},  {71'd0, busy_o}, 72'd0);
      check({tag, "_ack"},   {71'd0, wbs_ack_o}, 72'd0);
      check({tag, "_err"},   {71'd0, wbs_err_o}, 72'd0);
      check({tag, "_rdata"}, {40'd0, wbs_rdata_o}, 72'd0);
   endtask

   initial begin
      int unsigned dc;
      int          t;
      bit          we;
      logic [31:0] a, d;
      logic [3:0]  s;

      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      repeat (3) @(negedge clk);

      wb_access(1'b0, 32'h1000_0004, 32'h0, 4'h0, mk_rsp(0, 0, 0, 32'hDEAD_BEEF, 5), 1'b0, dc);
      wb_access(1'b1, 32'h2000_0000, 32'h1234_5678, 4'hF, mk_rsp(0, 0, 0, 32'h0, 3), 1'b1, dc);
      wb_access(1'b0, 32'h3000_0010, 32'h0, 4'h0, mk_rsp(0, 1, 0, 32'h5555_AAAA, 7), 1'b0, dc);
      wb_access(1'b0, 32'h4000_0000, 32'h0, 4'h0, mk_rsp(1, 0, 0, 32'h0, 0), 1'b0, dc);
      check("timeout_cycles", 72'(dc - fall_cyc), 72'(TIMEOUT));
      wb_access(1'b0, 32'h5000_0008, 32'h0, 4'h0, mk_rsp(0, 0, 1, 32'hCAFE_F00D, 4), 1'b0, dc);

      // Master abandons a write: frame and response still run, no pulse may appear.
      queue_access(1'b1, 32'h6000_0000, 32'hA5A5_5A5A, 4'h3, mk_rsp(0, 0, 0, 32'h0, 4), 1'b0);
      @(negedge clk);
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
      wbs_addr_i = 32'h6000_0000; wbs_wdata_i = 32'hA5A5_5A5A; wbs_sel_i = 4'h3;
      repeat (10) @(negedge clk);
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      t = 0;
      while (busy_o && t < 4000) begin @(negedge clk); t++; end
      check("abort_busy_cleared", {71'd0, busy_o}, 72'd0);
      repeat (10) @(negedge clk);

      // Reset in the middle of a write frame.
      queue_access(1'b1, 32'h7000_0000, 32'h0F0F_0F0F, 4'hC, mk_rsp(0, 0, 0, 32'h0, 4), 1'b0);
      @(negedge clk);
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
      wbs_addr_i = 32'h7000_0000; wbs_wdata_i = 32'h0F0F_0F0F; wbs_sel_i = 4'hC;
      t = 0;
      while (test_doen !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      check("rst_test_frame_started", {71'd0, test_doen}, 72'd1);
      repeat (20 * CLK_DIV) @(negedge clk);
      rst_abort = 1'b1;
      rst = 1'b1;
      #1;
      check_reset_outputs("midframe_reset");
      model_rdata = '0;
      void'(rsp_q.pop_back());
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      rst_abort = 1'b0;
      wb_access(1'b0, 32'h1000_0004, 32'h0, 4'h0, mk_rsp(0, 0, 0, 32'h0BAD_F00D, 6), 1'b0, dc);

      for (int i = 0; i < 16; i++) begin
         we = $urandom_range(0, 1);
         a  = $urandom;
         d  = $urandom;
         s  = 4'($urandom_range(0, 15));
         wb_access(we, a, d, s,
                   mk_rsp(0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                          $urandom, $urandom_range(2, 30)),
                   $urandom_range(0, 1), dc);
      end

      repeat (10) @(negedge clk);
      check("scoreboard_drained", 72'(exp_q.size() + frame_q.size() + rsp_q.size()), 72'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
